// File: rtl/pulse_sync_pkg.sv
// -----------------------------------------------------------------------------
// pulse_sync_pkg
// Shared constants for the pulse_sync_hs clock-domain-crossing block:
// default parameter values, legal parameter ranges and a small range-check
// helper used for elaboration-time parameter validation.
// No ports (package).
// -----------------------------------------------------------------------------
package pulse_sync_pkg;

  // Default parameter values
  localparam int NUM_CH_DEF      = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 3;

  // Legal parameter ranges (inclusive)
  localparam int NUM_CH_MIN      = 1;
  localparam int NUM_CH_MAX      = 32;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int CNT_W_MIN       = 1;
  localparam int CNT_W_MAX       = 8;

  // True when value lies within [lo, hi]; usable in constant expressions.
  function automatic bit in_range(input int value, input int lo, input int hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/pulse_sync_hs_if.sv
// -----------------------------------------------------------------------------
// pulse_sync_hs_if
// Bundles the per-channel event and status vectors of pulse_sync_hs.
//   i_pulse   [NUM_CH]  single-cycle events, i_clk domain (master -> slave)
//   i_clr_ovf [NUM_CH]  clears sticky overflow flag, i_clk domain (master -> slave)
//   o_busy    [NUM_CH]  crossing in flight or pulses pending, i_clk domain
//   o_ovf     [NUM_CH]  sticky pending-counter overflow, i_clk domain
//   o_pulse   [NUM_CH]  single-cycle events, o_clk domain
// master: the event producer / consumer side; slave: the synchronizer.
// -----------------------------------------------------------------------------
interface pulse_sync_hs_if
  import pulse_sync_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF
);

  logic [NUM_CH-1:0] i_pulse;
  logic [NUM_CH-1:0] i_clr_ovf;
  logic [NUM_CH-1:0] o_busy;
  logic [NUM_CH-1:0] o_ovf;
  logic [NUM_CH-1:0] o_pulse;

  modport master (
    output i_pulse,
    output i_clr_ovf,
    input  o_busy,
    input  o_ovf,
    input  o_pulse
  );

  modport slave (
    input  i_pulse,
    input  i_clr_ovf,
    output o_busy,
    output o_ovf,
    output o_pulse
  );

endinterface

// File: rtl/pulse_sync_hs_ch.sv
// -----------------------------------------------------------------------------
// pulse_sync_hs_ch
// One channel of the toggle-handshake pulse synchronizer. A source-side toggle
// (req) is carried into the destination domain, edge-detected into a single
// o_clk pulse, and the edge-detect flop is returned as ack. Pulses arriving
// while a crossing is in flight are queued in a saturating counter.
//   i_clk, i_rst_n   source clock / async active-low reset
//   o_clk, o_rst_n   destination clock / async active-low reset
//   i_pulse          single-cycle event (i_clk)
//   i_clr_ovf        clear sticky overflow (i_clk)
//   o_busy           in flight or pending (i_clk)
//   o_ovf            sticky overflow (i_clk)
//   o_pulse          registered single-cycle event (o_clk)
// -----------------------------------------------------------------------------
module pulse_sync_hs_ch
  import pulse_sync_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic o_clk,
  input  logic o_rst_n,
  input  logic i_pulse,
  input  logic i_clr_ovf,
  output logic o_busy,
  output logic o_ovf,
  output logic o_pulse
);

  if (!in_range(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX)) begin : g_bad_sync_stages
    $error("pulse_sync_hs_ch: SYNC_STAGES=%0d outside %0d..%0d",
           SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end
  if (!in_range(CNT_W, CNT_W_MIN, CNT_W_MAX)) begin : g_bad_cnt_w
    $error("pulse_sync_hs_ch: CNT_W=%0d outside %0d..%0d", CNT_W, CNT_W_MIN, CNT_W_MAX);
  end

  localparam logic [CNT_W-1:0] PEND_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  // Source-domain state
  logic                   r_req;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic [CNT_W-1:0]       r_pend;
  logic                   r_ovf;

  // Destination-domain state
  logic [SYNC_STAGES-1:0] r_req_sync;
  logic                   r_edge;
  logic                   r_pulse;

  logic w_ack;
  logic w_inf;
  logic w_pend_nz;
  logic w_launch;
  logic w_inc;
  logic w_dec;
  logic w_sat;

  assign w_ack     = r_ack_sync[SYNC_STAGES-1];
  assign w_inf     = r_req ^ w_ack;
  assign w_pend_nz = (r_pend != '0);

  // An idle channel launches straight from i_pulse; otherwise a launch drains
  // the queue. A pulse is queued whenever it cannot launch itself, which
  // includes the cycle a queued pulse launches (net counter change is zero).
  assign w_launch = ~w_inf & (i_pulse | w_pend_nz);
  assign w_inc    = i_pulse & (w_inf | w_pend_nz);
  assign w_dec    = ~w_inf & w_pend_nz;
  assign w_sat    = w_inc & ~w_dec & (r_pend == PEND_MAX);

  // Source side: req toggle, ack synchronizer, pending counter, sticky overflow.
  // Overflow set has priority over a simultaneous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req      <= 1'b0;
      r_ack_sync <= '0;
      r_pend     <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], r_edge};
      if (w_launch) begin
        r_req <= ~r_req;
      end
      if (w_inc && !w_dec && !w_sat) begin
        r_pend <= r_pend + PEND_ONE;
      end else if (w_dec && !w_inc) begin
        r_pend <= r_pend - PEND_ONE;
      end
      if (w_sat) begin
        r_ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Destination side: req synchronizer, edge-detect flop (doubles as ack)
  // and the registered output pulse.
  always_ff @(posedge o_clk or negedge o_rst_n) begin
    if (!o_rst_n) begin
      r_req_sync <= '0;
      r_edge     <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], r_req};
      r_edge     <= r_req_sync[SYNC_STAGES-1];
      r_pulse    <= r_req_sync[SYNC_STAGES-1] ^ r_edge;
    end
  end

  assign o_busy  = w_inf | w_pend_nz;
  assign o_ovf   = r_ovf;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/pulse_sync_hs.sv
// -----------------------------------------------------------------------------
// pulse_sync_hs
// Multi-channel toggle-handshake pulse synchronizer from the i_clk domain to
// the o_clk domain. Each channel is an independent pulse_sync_hs_ch; only
// flop outputs cross between the domains.
//   i_clk, i_rst_n   source clock / async active-low reset
//   o_clk, o_rst_n   destination clock / async active-low reset
//   io_bus           pulse_sync_hs_if.slave: i_pulse, i_clr_ovf in;
//                    o_busy, o_ovf, o_pulse out
// -----------------------------------------------------------------------------
module pulse_sync_hs
  import pulse_sync_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           o_clk,
  input  logic           o_rst_n,
  pulse_sync_hs_if.slave io_bus
);

  if (!in_range(NUM_CH, NUM_CH_MIN, NUM_CH_MAX)) begin : g_bad_num_ch
    $error("pulse_sync_hs: NUM_CH=%0d outside %0d..%0d", NUM_CH, NUM_CH_MIN, NUM_CH_MAX);
  end

  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_ovf;
  logic [NUM_CH-1:0] w_pulse;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pulse_sync_hs_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .o_clk     (o_clk),
      .o_rst_n   (o_rst_n),
      .i_pulse   (io_bus.i_pulse[g]),
      .i_clr_ovf (io_bus.i_clr_ovf[g]),
      .o_busy    (w_busy[g]),
      .o_ovf     (w_ovf[g]),
      .o_pulse   (w_pulse[g])
    );
  end

  assign io_bus.o_busy  = w_busy;
  assign io_bus.o_ovf   = w_ovf;
  assign io_bus.o_pulse = w_pulse;

endmodule

// File: tb/tb_pulse_sync_hs.sv
// -----------------------------------------------------------------------------
// tb_pulse_sync_hs
// Self-checking bench for pulse_sync_hs at default parameters. i_clk runs at
// 100 MHz, o_clk at 37 MHz (slowed to 10 MHz while the overflow case needs a
// long round trip). A monitor counts o_pulse cycles per channel; expectations
// come from an event-count model of the channel capacity.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pulse_sync_hs;
  import pulse_sync_pkg::*;

  localparam int NCH  = NUM_CH_DEF;
  localparam int SYNC = SYNC_STAGES_DEF;
  localparam int CW   = CNT_W_DEF;
  localparam int PMAX = (1 << CW) - 1;

  logic    i_clk   = 1'b0;
  logic    i_rst_n = 1'b0;
  logic    o_clk   = 1'b0;
  logic    o_rst_n = 1'b0;
  realtime oHalf   = 13.5;

  int checks   = 0;
  int failures = 0;
  int issued   [NCH];
  int deliv    [NCH];
  int lastEdge [NCH];
  int oEdgeCnt = 0;
  int aheadCnt = 0;

  pulse_sync_hs_if #(.NUM_CH(NCH)) bus ();

  pulse_sync_hs #(
    .NUM_CH      (NCH),
    .SYNC_STAGES (SYNC),
    .CNT_W       (CW)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_clk   (o_clk),
    .o_rst_n (o_rst_n),
    .io_bus  (bus)
  );

  // Clocks
  always #5 i_clk = ~i_clk;
  initial begin
    forever #(oHalf) o_clk = ~o_clk;
  end

  // Destination monitor: count o_pulse high cycles and note when they occur.
  always @(posedge o_clk) oEdgeCnt++;
  always @(negedge o_clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (bus.o_pulse[c] === 1'b1) begin
        deliv[c]++;
        lastEdge[c] = oEdgeCnt;
        if (deliv[c] > issued[c]) aheadCnt++;
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not complete, got=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Model: pulses issued back-to-back while a channel stays in flight; one
  // launches, up to PMAX queue, the rest are discarded.
  function automatic int model_delivered(input int burst);
    return (burst > PMAX + 1) ? PMAX + 1 : burst;
  endfunction

  function automatic bit model_ovf(input int burst);
    return burst > PMAX + 1;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_mask(input logic [NCH-1:0] m);
    bus.i_pulse = m;
    for (int c = 0; c < NCH; c++) if (m[c]) issued[c]++;
    tick();
    bus.i_pulse = '0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      tick();
      if (bus.o_busy === '0) ok = 1'b1;
    end
    repeat (3) @(negedge o_clk);
    tick();
  endtask

  task automatic test_reset();
    bus.i_pulse   = '0;
    bus.i_clr_ovf = '0;
    i_rst_n = 1'b0;
    o_rst_n = 1'b0;
    repeat (3) @(posedge o_clk);
    tick();
    checks++;
    if (bus.o_busy !== '0) begin
      failures++;
      $display("[TB] FAIL reset_busy got=%b expected=%b", bus.o_busy, 4'b0);
    end
    checks++;
    if (bus.o_ovf !== '0) begin
      failures++;
      $display("[TB] FAIL reset_ovf got=%b expected=%b", bus.o_ovf, 4'b0);
    end
    checks++;
    if (bus.o_pulse !== '0) begin
      failures++;
      $display("[TB] FAIL reset_pulse got=%b expected=%b", bus.o_pulse, 4'b0);
    end
    // Events presented while held in reset must be ignored
    bus.i_pulse = '1;
    tick();
    bus.i_pulse = '0;
    checks++;
    if (bus.o_busy !== '0) begin
      failures++;
      $display("[TB] FAIL reset_busy_pulse got=%b expected=%b", bus.o_busy, 4'b0);
    end
    i_rst_n = 1'b1;
    o_rst_n = 1'b1;
    repeat (20) tick();
    checks++;
    if (deliv[0] + deliv[1] + deliv[2] + deliv[3] !== 0) begin
      failures++;
      $display("[TB] FAIL reset_no_pulse got=%0d expected=0", deliv[0] + deliv[1] + deliv[2] + deliv[3]);
    end
  endtask

  task automatic test_single_pulse();
    int      base;
    int      n;
    bit      found;
    bit      ok;
    realtime tL;
    base  = deliv[0];
    n     = 0;
    found = 1'b0;
    tick();
    checks++;
    if (bus.o_busy[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_busy_before got=%b expected=0", bus.o_busy[0]);
    end
    bus.i_pulse = 4'b0001;
    issued[0]++;
    tL = $realtime + 9.0;
    fork
      begin
        tick();
        bus.i_pulse = '0;
        checks++;
        if (bus.o_busy[0] !== 1'b1) begin
          failures++;
          $display("[TB] FAIL single_busy_after got=%b expected=1", bus.o_busy[0]);
        end
      end
      begin
        for (int k = 0; k < 30 && !found; k++) begin
          @(posedge o_clk);
          if ($realtime > tL) n++;
          #1;
          if (bus.o_pulse[0] === 1'b1) found = 1'b1;
        end
      end
    join
    checks++;
    if (!found || n < SYNC + 1 || n > SYNC + 2) begin
      failures++;
      $display("[TB] FAIL single_latency got=%0d edges (found=%0b) expected=%0d..%0d",
               n, found, SYNC + 1, SYNC + 2);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL single_idle_timeout got=busy expected=idle");
    end
    checks++;
    if (deliv[0] - base !== 1) begin
      failures++;
      $display("[TB] FAIL single_count got=%0d expected=1", deliv[0] - base);
    end
    checks++;
    if (bus.o_busy[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_busy_end got=%b expected=0", bus.o_busy[0]);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    bit ok;
    base = deliv[1];
    for (int i = 0; i < 5; i++) pulse_mask(4'b0010);
    checks++;
    if (bus.o_busy[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_busy got=%b expected=1", bus.o_busy[1]);
    end
    wait_idle(ok);
    checks++;
    if (!ok || deliv[1] - base !== model_delivered(5)) begin
      failures++;
      $display("[TB] FAIL b2b_count got=%0d (idle=%0b) expected=%0d", deliv[1] - base, ok, model_delivered(5));
    end
    checks++;
    if (bus.o_ovf[1] !== model_ovf(5)) begin
      failures++;
      $display("[TB] FAIL b2b_ovf got=%b expected=%b", bus.o_ovf[1], model_ovf(5));
    end
  endtask

  task automatic test_overflow();
    int base;
    bit ok;
    oHalf = 50.0;
    repeat (3) @(posedge o_clk);
    tick();
    base = deliv[2];
    // Ninth pulse coincides with a clear request: the set must win
    for (int i = 0; i < 9; i++) begin
      bus.i_pulse = 4'b0100;
      issued[2]++;
      if (i == 8) bus.i_clr_ovf = 4'b0100;
      tick();
    end
    bus.i_pulse   = '0;
    bus.i_clr_ovf = '0;
    checks++;
    if (bus.o_ovf[2] !== model_ovf(9)) begin
      failures++;
      $display("[TB] FAIL ovf_set got=%b expected=%b", bus.o_ovf[2], model_ovf(9));
    end
    checks++;
    if ((bus.o_ovf & 4'b1011) !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL ovf_isolation got=%b expected=0000", bus.o_ovf & 4'b1011);
    end
    wait_idle(ok);
    checks++;
    if (!ok || deliv[2] - base !== model_delivered(9)) begin
      failures++;
      $display("[TB] FAIL ovf_count got=%0d (idle=%0b) expected=%0d", deliv[2] - base, ok, model_delivered(9));
    end
    checks++;
    if (bus.o_ovf[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_sticky got=%b expected=1", bus.o_ovf[2]);
    end
    bus.i_clr_ovf = 4'b0100;
    tick();
    bus.i_clr_ovf = '0;
    checks++;
    if (bus.o_ovf[2] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_clear got=%b expected=0", bus.o_ovf[2]);
    end
    oHalf = 13.5;
    repeat (3) @(posedge o_clk);
    tick();
  endtask

  task automatic test_all_channels();
    int base [NCH];
    int lo;
    int hi;
    bit ok;
    for (int c = 0; c < NCH; c++) base[c] = deliv[c];
    pulse_mask('1);
    wait_idle(ok);
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (!ok || deliv[c] - base[c] !== 1) begin
        failures++;
        $display("[TB] FAIL all_ch_count ch=%0d got=%0d expected=1", c, deliv[c] - base[c]);
      end
    end
    lo = lastEdge[0];
    hi = lastEdge[0];
    for (int c = 1; c < NCH; c++) begin
      if (lastEdge[c] < lo) lo = lastEdge[c];
      if (lastEdge[c] > hi) hi = lastEdge[c];
    end
    checks++;
    if (hi - lo > 1) begin
      failures++;
      $display("[TB] FAIL all_ch_skew got=%0d expected<=1", hi - lo);
    end
  endtask

  task automatic test_coincident();
    int base;
    bit ok;
    // Sweep the extra pulse across the window in which the queued launch occurs
    for (int d = 3; d <= 14; d++) begin
      base = deliv[3];
      for (int i = 0; i < 3; i++) pulse_mask(4'b1000);
      repeat (d) tick();
      pulse_mask(4'b1000);
      wait_idle(ok);
      checks++;
      if (!ok || deliv[3] - base !== 4) begin
        failures++;
        $display("[TB] FAIL coincident_count d=%0d got=%0d expected=4", d, deliv[3] - base);
      end
    end
    checks++;
    if (bus.o_ovf[3] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL coincident_ovf got=%b expected=0", bus.o_ovf[3]);
    end
  endtask

  task automatic test_reset_midflight();
    int snap;
    for (int i = 0; i < 4; i++) pulse_mask(4'b0001);
    repeat (2) tick();
    i_rst_n = 1'b0;
    o_rst_n = 1'b0;
    #1;
    snap = deliv[0];
    checks++;
    if (bus.o_busy !== '0 || bus.o_ovf !== '0 || bus.o_pulse !== '0) begin
      failures++;
      $display("[TB] FAIL midflight_reset_outputs got=%b/%b/%b expected=0000/0000/0000",
               bus.o_busy, bus.o_ovf, bus.o_pulse);
    end
    repeat (3) tick();
    i_rst_n = 1'b1;
    o_rst_n = 1'b1;
    repeat (60) tick();
    checks++;
    if (deliv[0] !== snap) begin
      failures++;
      $display("[TB] FAIL midflight_no_pulse got=%0d expected=%0d", deliv[0], snap);
    end
    checks++;
    if (bus.o_busy !== '0) begin
      failures++;
      $display("[TB] FAIL midflight_busy got=%b expected=0000", bus.o_busy);
    end
  endtask

  task automatic test_random();
    int             base [NCH];
    int             left [NCH];
    int             sent [NCH];
    logic [NCH-1:0] m;
    bit             ok;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < NCH; c++) begin
        base[c] = deliv[c];
        left[c] = $urandom_range(0, PMAX - 1);
        sent[c] = 0;
      end
      for (int cyc = 0; cyc < 40; cyc++) begin
        m = '0;
        for (int c = 0; c < NCH; c++) begin
          if (left[c] > 0 && $urandom_range(0, 1) == 1) begin
            m[c] = 1'b1;
            left[c]--;
            sent[c]++;
          end
        end
        pulse_mask(m);
      end
      wait_idle(ok);
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if (!ok || deliv[c] - base[c] !== sent[c]) begin
          failures++;
          $display("[TB] FAIL random_count round=%0d ch=%0d got=%0d expected=%0d",
                   r, c, deliv[c] - base[c], sent[c]);
        end
      end
      checks++;
      if (bus.o_ovf !== '0) begin
        failures++;
        $display("[TB] FAIL random_ovf round=%0d got=%b expected=0000", r, bus.o_ovf);
      end
    end
    checks++;
    if (aheadCnt !== 0) begin
      failures++;
      $display("[TB] FAIL pulse_before_event got=%0d expected=0", aheadCnt);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single_pulse();
    test_back_to_back();
    test_overflow();
    test_all_channels();
    test_coincident();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_sync_hs.md
PULSE_SYNC_HS -- requirements
Module: pulse_sync_hs

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent pulse channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flops per crossing (2..4).
REQ-003 SHALL have parameter CNT_W, default 3, width of per-channel pending-pulse counter (1..8).
REQ-004 SHALL have port i_clk  input  1  source-domain clock.
REQ-005 SHALL have port i_rst_n  input  1  source-domain reset, asynchronous, active-low.
REQ-006 SHALL have port o_clk  input  1  destination-domain clock.
REQ-007 SHALL have port o_rst_n  input  1  destination-domain reset, asynchronous, active-low.
REQ-008 SHALL have port i_pulse  input  NUM_CH  single-cycle event per channel, i_clk domain.
REQ-009 SHALL have port i_clr_ovf  input  NUM_CH  clears matching o_ovf bit, i_clk domain.
REQ-010 SHALL have port o_busy  output  NUM_CH  channel crossing in flight or pulses pending, i_clk domain.
REQ-011 SHALL have port o_ovf  output  NUM_CH  sticky pending-counter overflow flag, i_clk domain.
REQ-012 SHALL have port o_pulse  output  NUM_CH  registered single-cycle event per channel, o_clk domain.

Function
REQ-013 Each channel SHALL hold a source toggle req, a SYNC_STAGES-flop ack synchronizer, and an unsigned CNT_W-bit counter pend.
REQ-014 Channel in-flight flag inf SHALL equal req XOR synchronized ack; o_busy SHALL equal inf OR (pend != 0).
REQ-015 i_pulse high with inf=0 and pend=0 SHALL toggle req at the next i_clk edge (launch); o_busy high from the following cycle.
REQ-016 i_pulse high with inf=1 SHALL increment pend by one at the next i_clk edge.
REQ-017 With inf=0 and pend>0, the channel SHALL launch and decrement pend; a coincident i_pulse SHALL increment pend, so pend is unchanged net.
REQ-018 An increment at pend = 2^CNT_W-1 SHALL leave pend saturated, discard the pulse, and set o_ovf at the next edge.
REQ-019 o_ovf SHALL stay set until i_clr_ovf is high for one cycle; simultaneous set and clear SHALL leave o_ovf set.
REQ-020 Destination SHALL synchronize req through SYNC_STAGES o_clk flops plus one edge-detect flop; o_pulse SHALL be registered as last-stage XOR edge-detect flop.
REQ-021 o_pulse SHALL be high exactly one o_clk cycle per launch, SYNC_STAGES+1 o_clk edges after req toggles (+1 edge metastability uncertainty).
REQ-022 The edge-detect flop output SHALL be the ack returned to the source domain; inf clears SYNC_STAGES i_clk edges after ack toggles.
REQ-023 Every accepted i_pulse SHALL produce exactly one o_pulse; no pulse SHALL be lost or duplicated unless o_ovf is set.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL not interact.
REQ-025 No combinational path SHALL cross domains; only req and ack flop outputs cross.

Reset
REQ-026 i_rst_n low SHALL clear req, ack synchronizers, pend and o_ovf; o_busy reads 0 during reset.
REQ-027 o_rst_n low SHALL clear req synchronizers, edge-detect flop and o_pulse.
REQ-028 Both resets SHALL be asserted together for normal reset; independent o_rst_n during flight SHALL produce at most one spurious o_pulse per channel and no X.
REQ-029 Reset deassertion SHALL be synchronized externally per domain; the block adds no reset synchronizers.

Structure
REQ-030 Package pulse_sync_pkg SHALL hold default constants NUM_CH_DEF, SYNC_STAGES_DEF, CNT_W_DEF and parameter range limits.
REQ-031 Sub-module pulse_sync_hs_ch SHALL implement one channel; top SHALL generate NUM_CH instances.
REQ-032 Illegal parameter values SHALL trigger an elaboration-time error.

Verification
REQ-033 Single pulse ch0, i_clk 100 MHz, o_clk 37 MHz, defaults -> one o_pulse[0] 3-4 o_clk edges after req toggle; o_busy[0] low afterwards.
REQ-034 5 back-to-back i_pulse[1] (CNT_W=3) -> pend peaks at 4, exactly 5 o_pulse[1], o_ovf[1]=0.
REQ-035 9 back-to-back i_pulse[2] at CNT_W=3 -> 8 o_pulse[2], o_ovf[2]=1, cleared by i_clr_ovf[2].
REQ-036 i_pulse on all 4 channels in the same cycle -> 4 o_pulse, one per channel, same o_clk cycle +/-1.
REQ-037 i_pulse coincident with pending launch (pend=2) -> pend stays 2 that edge; total o_pulse count equals accepted pulses.
REQ-038 Both resets asserted mid-flight with pend=3 -> all outputs 0; after release no o_pulse without new i_pulse.
